// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract: one DW-bit digit per clock, LSB digit first, through a
// registered carry. start/busy/done handshake; sum/cout/ovf hold until the next accepted start.
module serial_digit_adder #(
  parameter int DW = 4,
  parameter int ND = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             cin,
  input  logic [DW*ND-1:0] a_in,
  input  logic [DW*ND-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [DW*ND-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int TW = DW * ND;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshake: start is only a request and is sampled in IDLE alone; there is no
  // ready/queue, so a start seen in RUN or DONE is dropped. done is a one-cycle strobe.
  logic [1:0]    state;
  logic [TW-1:0] a_q;
  logic [TW-1:0] b_q;
  logic          mode_q;
  logic          carry_q;
  logic [CW-1:0] cnt;

  logic [DW-1:0] a_dig;
  logic [DW-1:0] b_dig;
  logic [DW:0]   dig_r;
  logic          last_dig;

  always_comb begin
    a_dig    = a_q[int'(cnt) * DW +: DW];
    b_dig    = b_q[int'(cnt) * DW +: DW];
    dig_r    = {1'b0, a_dig} + {1'b0, b_dig} + {{DW{1'b0}}, carry_q};
    last_dig = (cnt == CW'(ND - 1));
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + ~borrow, so the borrow-in enters inverted as carry.
            a_q     <= a_in;
            b_q     <= mode ? ~b_in : b_in;
            mode_q  <= mode;
            carry_q <= mode ? ~cin : cin;
            cnt     <= '0;
            sum     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[int'(cnt) * DW +: DW] <= dig_r[DW-1:0];
          carry_q <= dig_r[DW];
          if (last_dig) begin
            cnt   <= '0;
            cout  <= mode_q ? ~dig_r[DW] : dig_r[DW];
            ovf   <= (a_q[TW-1] == b_q[TW-1]) && (dig_r[DW-1] != a_q[TW-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
